// File: rtl/sw_pattern_recorder_if.sv
// Switch/LED-side bundle for the pattern recorder: raw switches in,
// debounced levels, edge pulses and the recorded pattern out.
interface sw_pattern_recorder_if;
  logic [3:0]  SW;
  logic [3:0]  SW_CLEAN;
  logic [3:0]  SW_RISE;
  logic [3:0]  SW_FALL;
  logic [31:0] PATTERN;
  logic        PATTERN_VALID;
  logic        BUSY;

  modport slave (
    input  SW,
    output SW_CLEAN, SW_RISE, SW_FALL, PATTERN, PATTERN_VALID, BUSY
  );

  modport master (
    output SW,
    input  SW_CLEAN, SW_RISE, SW_FALL, PATTERN, PATTERN_VALID, BUSY
  );
endinterface

// File: rtl/sw_pattern_recorder.sv
// Switch pattern recorder: synchronizes and debounces four switches, then
// records SW1 into a 32-slot pattern at the LED blink slot rate after a
// start press (SW2) and a leading data edge (SW1). SW3 clears, SW4 aborts.
module sw_pattern_recorder #(
  parameter int unsigned DEBOUNCE_CYCLES = 16000,
  parameter int unsigned TICK_LOG2       = 21
) (
  input logic                  CLK,
  input logic                  RST,
  sw_pattern_recorder_if.slave bus
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RECORD,
    S_DONE
  } state_t;

  logic [3:0]            sync1_q, sync2_q;
  logic [3:0]            clean_q, clean_d;
  logic [3:0]            rise_q, rise_d;
  logic [3:0]            fall_q, fall_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;

  state_t                state_q, state_d;
  logic [31:0]           pattern_q, pattern_d;
  logic                  valid_q, valid_d;
  logic [TICK_LOG2-1:0]  tick_q, tick_d;
  logic [4:0]            idx_q, idx_d;

  // Per-switch debounce: accept the synced level after DEBOUNCE_CYCLES of disagreement
  always_comb begin
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    cnt_d   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          clean_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Recorder next state; abort > clear > start > data
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    valid_d   = valid_q;
    tick_d    = tick_q;
    idx_d     = idx_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (rise_q[2]) begin
          state_d   = S_IDLE;
          pattern_d = '0;
          valid_d   = 1'b0;
        end else if (rise_q[1]) begin
          state_d   = S_ARMED;
          pattern_d = '0;
          valid_d   = 1'b0;
        end
      end
      S_ARMED, S_RECORD: begin
        if (rise_q[3]) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end else if (rise_q[1]) begin
          state_d   = S_ARMED;
          pattern_d = '0;
          valid_d   = 1'b0;
        end else if (state_q == S_ARMED) begin
          if (rise_q[0]) begin
            state_d      = S_RECORD;
            pattern_d[0] = 1'b1;
            tick_d       = '0;
            idx_d        = 5'd1;
          end
        end else if (idx_q == 5'd0) begin
          // Index wraps to 0 only after slot 31 was written: recording complete
          state_d = S_DONE;
          valid_d = 1'b1;
        end else begin
          tick_d = tick_q + TICK_LOG2'(1);
          if (tick_q == '1) begin
            pattern_d[idx_q] = clean_q[0];
            idx_d            = idx_q + 5'd1;
          end
        end
      end
    endcase
  end

  // All registers: synchronizers, debounce state and recorder state
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      clean_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      cnt_q     <= '0;
      state_q   <= S_IDLE;
      pattern_q <= '0;
      valid_q   <= 1'b0;
      tick_q    <= '0;
      idx_q     <= '0;
    end else begin
      sync1_q   <= bus.SW;
      sync2_q   <= sync1_q;
      clean_q   <= clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      pattern_q <= pattern_d;
      valid_q   <= valid_d;
      tick_q    <= tick_d;
      idx_q     <= idx_d;
    end
  end

  assign bus.SW_CLEAN      = clean_q;
  assign bus.SW_RISE       = rise_q;
  assign bus.SW_FALL       = fall_q;
  assign bus.PATTERN       = pattern_q;
  assign bus.PATTERN_VALID = valid_q;
  assign bus.BUSY          = (state_q == S_ARMED) || (state_q == S_RECORD);

endmodule

// File: tb/tb_sw_pattern_recorder.sv
// Bench for sw_pattern_recorder with short debounce and slot period.
// A reference model built from window/time arithmetic is compared every cycle.
module tb_sw_pattern_recorder;
  localparam int unsigned DB     = 4;
  localparam int unsigned TL     = 3;
  localparam int unsigned PERIOD = 1 << TL;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] sw;

  sw_pattern_recorder_if bus();
  assign bus.SW = sw;

  sw_pattern_recorder #(.DEBOUNCE_CYCLES(DB), .TICK_LOG2(TL)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef enum int {M_IDLE, M_ARMED, M_REC, M_DONE} mmode_t;
  mmode_t      m_mode;
  logic [31:0] m_pat;
  logic        m_val;
  logic [3:0]  m_clean, m_rise, m_fall;
  logic [3:0]  sw_hist[$];
  logic [3:0]  syn_hist[$];
  int unsigned since[4];
  int unsigned edge_n = 0;
  int unsigned rec_start = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference behaviour
  task automatic model_step(input logic rst_now, input logic [3:0] sw_now);
    logic [3:0]  synced;
    logic        stable;
    int unsigned d;
    edge_n++;
    if (rst_now) begin
      m_mode  = M_IDLE;
      m_pat   = '0;
      m_val   = 1'b0;
      m_clean = '0;
      m_rise  = '0;
      m_fall  = '0;
      sw_hist.delete();
      sw_hist.push_back(4'h0);
      sw_hist.push_back(4'h0);
      syn_hist.delete();
      for (int i = 0; i < 4; i++) since[i] = 0;
      return;
    end
    case (m_mode)
      M_IDLE, M_DONE: begin
        if (m_rise[2]) begin
          m_mode = M_IDLE; m_pat = '0; m_val = 1'b0;
        end else if (m_rise[1]) begin
          m_mode = M_ARMED; m_pat = '0; m_val = 1'b0;
        end
      end
      M_ARMED, M_REC: begin
        if (m_rise[3]) begin
          m_mode = M_IDLE; m_val = 1'b0;
        end else if (m_rise[1]) begin
          m_mode = M_ARMED; m_pat = '0; m_val = 1'b0;
        end else if (m_mode == M_ARMED) begin
          if (m_rise[0]) begin
            m_mode = M_REC; m_pat[0] = 1'b1; rec_start = edge_n;
          end
        end else begin
          d = edge_n - rec_start;
          if (d == 31 * PERIOD + 1) begin
            m_mode = M_DONE; m_val = 1'b1;
          end else if (d % PERIOD == 0) begin
            m_pat[d / PERIOD] = m_clean[0];
          end
        end
      end
      default: ;
    endcase
    // A level is accepted once the last DB synced samples all disagree with it
    synced = sw_hist[sw_hist.size() - 2];
    syn_hist.push_back(synced);
    if (syn_hist.size() > DB) void'(syn_hist.pop_front());
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < 4; i++) begin
      since[i]++;
      stable = (since[i] >= DB);
      foreach (syn_hist[j]) if (syn_hist[j][i] == m_clean[i]) stable = 1'b0;
      if (stable) begin
        m_clean[i] = ~m_clean[i];
        m_rise[i]  = m_clean[i];
        m_fall[i]  = ~m_clean[i];
        since[i]   = 0;
      end
    end
    sw_hist.push_back(sw_now);
    if (sw_hist.size() > 4) void'(sw_hist.pop_front());
  endtask

  task automatic step();
    @(posedge CLK);
    model_step(RST, sw);
    #1;
    check("SW_CLEAN", 32'(bus.SW_CLEAN), 32'(m_clean));
    check("SW_RISE", 32'(bus.SW_RISE), 32'(m_rise));
    check("SW_FALL", 32'(bus.SW_FALL), 32'(m_fall));
    check("PATTERN", bus.PATTERN, m_pat);
    check("PATTERN_VALID", 32'(bus.PATTERN_VALID), 32'(m_val));
    check("BUSY", 32'(bus.BUSY), 32'((m_mode == M_ARMED) || (m_mode == M_REC)));
  endtask

  task automatic press(input int b);
    sw[b] = 1'b1;
    repeat (8) step();
    sw[b] = 1'b0;
    repeat (8) step();
  endtask

  task automatic wait_valid(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      step();
      if (bus.PATTERN_VALID === 1'b1) got = 1'b1;
    end
    check(tag, 32'(got), 32'd1);
  endtask

  initial begin
    int   n, rises, falls;
    logic got;
    logic [31:0] p;

    RST = 1'b1;
    sw  = '0;
    repeat (3) step();
    check("rst_pattern", bus.PATTERN, 32'h0);
    check("rst_valid", 32'(bus.PATTERN_VALID), 32'd0);
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_clean", 32'(bus.SW_CLEAN), 32'd0);
    RST = 1'b0;
    repeat (4) step();

    // Bounce on SW1, then a final hold at 1
    for (int i = 0; i < 10; i++) begin
      sw[0] = ~sw[0];
      step();
      step();
    end
    sw[0] = 1'b1;
    n = 0; rises = 0; falls = 0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!got) n++;
      if (bus.SW_CLEAN[0] === 1'b1) got = 1'b1;
      if (bus.SW_RISE[0] === 1'b1) rises++;
      if (bus.SW_FALL[0] === 1'b1) falls++;
    end
    check("bounce_delay", 32'(n), 32'd6);
    check("bounce_rises", 32'(rises), 32'd1);
    check("bounce_falls", 32'(falls), 32'd0);
    sw[0] = 1'b0;
    repeat (10) step();

    // Full capture: SW1 held 40 cycles
    press(1);
    check("armed_busy", 32'(bus.BUSY), 32'd1);
    sw[0] = 1'b1;
    repeat (40) step();
    sw[0] = 1'b0;
    wait_valid("cap_wait");
    check("cap_pattern", bus.PATTERN, 32'h0000_001F);
    check("cap_valid", 32'(bus.PATTERN_VALID), 32'd1);
    check("cap_busy", 32'(bus.BUSY), 32'd0);
    repeat (5) step();
    check("done_hold", bus.PATTERN, 32'h0000_001F);

    // Alternating pattern aligned to the slot ticks
    press(1);
    sw[0] = 1'b1;
    for (int k = 0; k < 31; k++) begin
      repeat (8) step();
      sw[0] = ~sw[0];
    end
    repeat (7) step();
    check("alt_pattern", bus.PATTERN, 32'h5555_5555);
    check("alt_valid_early", 32'(bus.PATTERN_VALID), 32'd0);
    step();
    check("alt_valid", 32'(bus.PATTERN_VALID), 32'd1);
    check("alt_busy", 32'(bus.BUSY), 32'd0);
    sw[0] = 1'b0;
    repeat (10) step();

    // Clear from DONE
    press(2);
    check("clear_pattern", bus.PATTERN, 32'h0);
    check("clear_valid", 32'(bus.PATTERN_VALID), 32'd0);

    // Abort at bit 10
    press(1);
    sw[0] = 1'b1;
    repeat (76) step();
    sw[3] = 1'b1;
    repeat (6) step();
    check("abort_pre_busy", 32'(bus.BUSY), 32'd1);
    step();
    p = bus.PATTERN;
    check("abort_busy", 32'(bus.BUSY), 32'd0);
    check("abort_valid", 32'(bus.PATTERN_VALID), 32'd0);
    check("abort_hi", 32'(p[31:10]), 32'd0);
    check("abort_lo", 32'(p[9:0]), 32'h3FF);
    sw[3] = 1'b0;
    sw[0] = 1'b0;
    repeat (12) step();

    // Start and abort rising together while recording
    press(1);
    sw[0] = 1'b1;
    repeat (30) step();
    sw[1] = 1'b1;
    sw[3] = 1'b1;
    repeat (7) step();
    check("prio_busy", 32'(bus.BUSY), 32'd0);
    check("prio_valid", 32'(bus.PATTERN_VALID), 32'd0);
    sw = '0;
    repeat (12) step();

    // Reset pulse mid-recording, switch held through release
    press(1);
    sw[0] = 1'b1;
    repeat (40) step();
    check("rec_busy", 32'(bus.BUSY), 32'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("rstrec_pattern", bus.PATTERN, 32'h0);
    check("rstrec_busy", 32'(bus.BUSY), 32'd0);
    check("rstrec_clean", 32'(bus.SW_CLEAN), 32'd0);
    check("rstrec_valid", 32'(bus.PATTERN_VALID), 32'd0);
    n = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      n++;
      if (bus.SW_RISE[0] === 1'b1) got = 1'b1;
    end
    check("held_rise_delay", 32'(n), 32'd6);
    sw[0] = 1'b0;
    repeat (10) step();
    press(1);
    sw[0] = 1'b1;
    repeat (16) step();
    sw[0] = 1'b0;
    wait_valid("post_rst_wait");
    check("post_rst_pattern", bus.PATTERN, 32'h0000_0003);

    // Random switch activity against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) sw[0] = ~sw[0];
      if ($urandom_range(0, 199) == 0) sw[1] = ~sw[1];
      if ($urandom_range(0, 399) == 0) sw[2] = ~sw[2];
      if ($urandom_range(0, 599) == 0) sw[3] = ~sw[3];
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_pattern_recorder.md
SW_PATTERN_RECORDER -- requirements
Module: sw_pattern_recorder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16000, stable-input cycles (1 ms at 16 MHz) before a switch change is accepted.
REQ-002 SHALL have parameter TICK_LOG2, default 21, so the bit period is 2^TICK_LOG2 CLK cycles, the same slot rate at which the LED side plays a 32-bit blink pattern.
REQ-003 SHALL have port CLK, input, 1, the single 16 MHz clock; all logic on posedge CLK.
REQ-004 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-005 SHALL have port SW, input, 4, raw asynchronous switches; SW[0]=SW1 data, SW[1]=SW2 start, SW[2]=SW3 clear, SW[3]=SW4 abort.
REQ-006 SHALL have port SW_CLEAN, output, 4, debounced switch levels.
REQ-007 SHALL have port SW_RISE, output, 4, one-cycle pulse per bit on each 0->1 of SW_CLEAN.
REQ-008 SHALL have port SW_FALL, output, 4, one-cycle pulse per bit on each 1->0 of SW_CLEAN.
REQ-009 SHALL have port PATTERN, output, 32, the recorded pattern, slot 0 in bit 0.
REQ-010 SHALL have port PATTERN_VALID, output, 1, high while PATTERN holds a complete recording.
REQ-011 SHALL have port BUSY, output, 1, high in ARMED or RECORD.

Function
REQ-012 SHALL pass each SW bit through a 2-flop synchronizer before any other use.
REQ-013 SHALL keep one debounce counter per switch:
- If synced != SW_CLEAN, the counter increments.
- If synced == SW_CLEAN, the counter clears to 0.
- On the cycle the counter equals DEBOUNCE_CYCLES-1, SW_CLEAN takes the synced value and the counter clears.
REQ-014 SHALL assert SW_RISE/SW_FALL on the same cycle SW_CLEAN changes, for exactly one cycle.
REQ-015 SHALL implement FSM states IDLE, ARMED, RECORD and DONE.
REQ-016 SHALL use the following transitions:
- IDLE or DONE -> ARMED on SW_RISE[1], clearing PATTERN to 0 and PATTERN_VALID to 0.
- ARMED -> RECORD on SW_RISE[0].
REQ-017 SHALL, on the ARMED->RECORD transition, write PATTERN[0]=1, clear the tick counter to 0 and set the bit index to 1.
REQ-018 SHALL, in RECORD, increment a TICK_LOG2-bit tick counter every cycle, wrapping to 0.
REQ-019 SHALL, in RECORD, on each cycle the tick counter equals 2^TICK_LOG2-1, write SW_CLEAN[0] into PATTERN[bit index] and increment the bit index.
REQ-020 SHALL make bit k's sample time k*2^TICK_LOG2 cycles after the start-bit write.
REQ-021 SHALL, when bit 31 is written, move to DONE on the next clock and assert PATTERN_VALID on that same edge.
REQ-022 SHALL hold PATTERN and PATTERN_VALID constant in DONE.
REQ-023 SHALL, on SW_RISE[2] in DONE or IDLE, clear PATTERN to 0 and PATTERN_VALID to 0, and go to IDLE.
REQ-024 SHALL, on SW_RISE[3] in ARMED or RECORD, go to IDLE with PATTERN_VALID=0 and the partially recorded PATTERN retained.
REQ-025 SHALL ignore SW_RISE[3] in IDLE and DONE.
REQ-026 SHALL resolve events on the same cycle by the priority abort > clear > start > data.
REQ-027 SHALL restart the recording when SW_RISE[1] occurs in ARMED or RECORD, exactly as REQ-016 from IDLE.
REQ-028 SHALL ignore SW_RISE[0] outside ARMED; SW_CLEAN[0] edges in RECORD only matter at sample ticks.
REQ-029 SHALL keep the bit index at 5 bits, never exceeding 31 while writing; the tick counter wraps without saturating.

Reset
REQ-030 SHALL, while RST=1 on a clock edge, set:
- state to IDLE;
- synchronizers, SW_CLEAN and debounce counters to 0;
- SW_RISE, SW_FALL, PATTERN, PATTERN_VALID and BUSY to 0;
- tick counter and bit index to 0.
REQ-031 SHALL make RST asserted mid-recording discard the recording with no partial PATTERN retained.
REQ-032 SHALL treat a switch held at 1 through reset release as a change, producing SW_RISE DEBOUNCE_CYCLES+2 cycles after release.

Verification (DEBOUNCE_CYCLES=4, TICK_LOG2=3)
REQ-033 SHALL cover bounce: SW[0] toggling every 2 cycles for 20 cycles then held 1 -> SW_CLEAN[0] rises exactly 6 cycles after the last toggle, with one SW_RISE[0] pulse and no SW_FALL[0].
REQ-034 SHALL cover full capture: start, then SW1 held 1 for 40 cycles then 0 -> PATTERN=0x0000001F, PATTERN_VALID=1, BUSY=0.
REQ-035 SHALL cover alternate pattern: SW1 toggled every 8 cycles, aligned to the ticks after the start bit -> PATTERN=0x55555555 and PATTERN_VALID 1 cycle after bit 31.
REQ-036 SHALL cover abort: SW4 rise during RECORD at bit 10 -> IDLE, BUSY=0, PATTERN_VALID=0, PATTERN[31:10]=0.
REQ-037 SHALL cover priority: SW2 and SW4 rising on the same cycle in RECORD -> abort wins and the state is IDLE.
REQ-038 SHALL cover reset: RST pulsed 1 cycle in RECORD -> all outputs 0 next cycle; a new start afterwards records normally.
